// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register master: mode constants, command-byte layout and FSM states.
package spi_reg_pkg;

    localparam logic CPOL       = 1'b1;
    localparam logic CPHA       = 1'b1;
    localparam int   REG_BYTE_W = 8;
    localparam int   RW_BIT     = REG_BYTE_W - 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        BYTE,
        GAP,
        HOLD,
        RECOVER
    } mst_state_t;

    // Command byte: rw in the top bit, zero-extended address below it.
    function automatic logic [REG_BYTE_W-1:0] make_cmd(input logic rw, input logic [RW_BIT-1:0] addr);
        return {rw, addr};
    endfunction

endpackage

// File: rtl/spi_reg_master_clk_div.sv
// Half-period tick generator for the SPI master; counts enabled cycles, restartable on accept.
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rstb,
    input  logic ena,
    input  logic restart,
    output logic tick
);

    logic [7:0] cnt;

    assign tick = ena && (cnt == 8'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rstb) begin
            cnt <= '0;
        end else if (ena) begin
            if (restart || tick) cnt <= '0;
            else                 cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/spi_reg_master.sv
// SPI mode-3 register master: one request becomes a command byte plus a data byte in one cs_n frame.
// Optional read-back of every write when SPI_REG_MASTER_WRITE_VERIFY_EN is defined.
module spi_reg_master
    import spi_reg_pkg::*;
#(
    parameter int ADDR_W  = 3,
    parameter int REG_W   = 8,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              ena,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [REG_W-1:0]  req_wdata,
    output logic              rsp_valid,
    output logic [REG_W-1:0]  rsp_rdata,
    output logic [REG_W-1:0]  rsp_status,
    output logic              rsp_err,
    output logic              busy,
    output logic              spi_clk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic              spi_cs_n
);

    mst_state_t        state;
    logic              tick;
    logic              accept;
    logic [2:0]        bit_cnt;
    logic              byte_idx;
    logic              half_cnt;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [REG_W-1:0]  wdata_q;
    logic [REG_W-1:0]  tx_sr;
    logic [REG_W-1:0]  rx_sr;
    logic [REG_W-1:0]  status_q;
`ifdef SPI_REG_MASTER_WRITE_VERIFY_EN
    logic              verify_q;
`else
    assign rsp_err = 1'b0;
`endif

    // Request handshake: a transfer happens on req_valid & req_ready & ena; req_ready is high only in IDLE.
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = req_valid & req_ready & ena;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk     (clk),
        .rstb    (rstb),
        .ena     (ena),
        .restart (accept),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state      <= IDLE;
            spi_cs_n   <= 1'b1;
            spi_clk    <= CPOL;
            spi_mosi   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_status <= '0;
            bit_cnt    <= '0;
            byte_idx   <= 1'b0;
            half_cnt   <= 1'b0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            status_q   <= '0;
`ifdef SPI_REG_MASTER_WRITE_VERIFY_EN
            rsp_err    <= 1'b0;
            verify_q   <= 1'b0;
`endif
        end else if (ena) begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    state    <= SETUP;
                    spi_cs_n <= 1'b0;
                    rw_q     <= req_rw;
                    addr_q   <= req_addr;
                    wdata_q  <= req_wdata;
                    tx_sr    <= make_cmd(req_rw, RW_BIT'(req_addr));
                    byte_idx <= 1'b0;
`ifdef SPI_REG_MASTER_WRITE_VERIFY_EN
                    verify_q <= 1'b0;
`endif
                end
                SETUP: if (tick) begin
                    state    <= BYTE;
                    spi_clk  <= 1'b0;
                    spi_mosi <= tx_sr[REG_W-1];
                    bit_cnt  <= '0;
                end
                BYTE: if (tick) begin
                    if (!spi_clk) begin
                        spi_clk <= 1'b1;
                        rx_sr   <= {rx_sr[REG_W-2:0], spi_miso};
                    end else if (bit_cnt == 3'd7) begin
                        bit_cnt <= '0;
                        if (!byte_idx) begin
                            state    <= GAP;
                            half_cnt <= 1'b0;
                            byte_idx <= 1'b1;
                            status_q <= rx_sr;
                            tx_sr    <= rw_q ? wdata_q : '0;
                        end else begin
                            state    <= HOLD;
                            byte_idx <= 1'b0;
                        end
                    end else begin
                        // Falling edge: shift the next bit out.
                        bit_cnt  <= bit_cnt + 3'd1;
                        spi_clk  <= 1'b0;
                        spi_mosi <= tx_sr[REG_W-2];
                        tx_sr    <= {tx_sr[REG_W-2:0], 1'b0};
                    end
                end
                GAP: if (tick) begin
                    if (half_cnt) begin
                        state    <= BYTE;
                        spi_clk  <= 1'b0;
                        spi_mosi <= tx_sr[REG_W-1];
                    end else begin
                        half_cnt <= 1'b1;
                    end
                end
                HOLD: if (tick) begin
                    state    <= RECOVER;
                    half_cnt <= 1'b0;
                    spi_cs_n <= 1'b1;
                    spi_mosi <= 1'b0;
`ifdef SPI_REG_MASTER_WRITE_VERIFY_EN
                    // A write frame is silent; its response comes from the read-back frame.
                    if (!rw_q) begin
                        rsp_valid  <= 1'b1;
                        rsp_status <= status_q;
                        rsp_rdata  <= rx_sr;
                        rsp_err    <= verify_q && (rx_sr != wdata_q);
                    end
`else
                    rsp_valid  <= 1'b1;
                    rsp_status <= status_q;
                    rsp_rdata  <= rw_q ? '0 : rx_sr;
`endif
                end
                RECOVER: if (tick) begin
                    if (half_cnt) begin
`ifdef SPI_REG_MASTER_WRITE_VERIFY_EN
                        if (rw_q) begin
                            state    <= SETUP;
                            spi_cs_n <= 1'b0;
                            rw_q     <= 1'b0;
                            verify_q <= 1'b1;
                            tx_sr    <= make_cmd(1'b0, RW_BIT'(addr_q));
                        end else begin
                            state <= IDLE;
                        end
`else
                        state <= IDLE;
`endif
                    end else begin
                        half_cnt <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/spi_reg_master.md
# spi_reg_master

SPI mode-3 initiator that issues single-register read/write frames to the team's SPI register slave. It converts a valid/ready request (rw, address, write data) into one chip-select frame: a command byte, then a data byte. It returns the status byte and the read data on a one-cycle response strobe. It sits in test/bridge logic on the host side of the register link, running from the system clock.

## Interface
Parameters:
- ADDR_W, 3, register address width; must be ≤ REG_W-1.
- REG_W, 8, byte width; fixed at 8.
- CLK_DIV, 4, enabled clk cycles per SPI half-period; legal range 4..255.

Ports:
- clk  in  1  system clock.
- rstb  in  1  reset, synchronous, active-low.
- ena  in  1  clock enable; when low, all state and outputs hold.
- req_valid  in  1  request present.
- req_ready  out  1  high in IDLE; transfer on req_valid & req_ready & ena.
- req_rw  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  register address.
- req_wdata  in  REG_W  write data; ignored for reads.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  REG_W  read data; 0 for writes, or the readback under the verify option.
- rsp_status  out  REG_W  byte shifted in during the command byte.
- rsp_err  out  1  write-verify mismatch; valid with rsp_valid.
- busy  out  1  high from accept until req_ready returns.
- spi_clk  out  1  SPI clock; idle high.
- spi_mosi  out  1  master out.
- spi_miso  in  1  master in.
- spi_cs_n  out  1  chip select, active-low.

## Operation
- Request fields are captured on accept.
- Command byte = {rw, zeros, addr}: rw in bit REG_W-1, addr in bits ADDR_W-1:0.
- Byte 2 carries wdata on a write and 0x00 on a read.
- All bits are sent MSB first.
- Mode 3 (CPOL=1, CPHA=1):
  - spi_mosi changes on each spi_clk falling edge.
  - spi_miso is sampled into a shift register on each rising edge.
- The bits captured during the command byte become rsp_status. The bits captured during byte 2 become rsp_rdata on reads.
- States:
  - IDLE: cs_n=1, clk=1. On accept go to SETUP.
  - SETUP: cs_n=0 for 1 half-period, then go to BYTE (index 0).
  - BYTE: 16 half-periods, falling edge first, 8 bits; the 3-bit bit counter wraps 7→0. After byte 0 go to GAP; after byte 1 go to HOLD.
  - GAP: clk held high for 2 half-periods, then BYTE (index 1).
  - HOLD: 1 half-period, then cs_n=1 and rsp_valid pulses on that same cycle; go to RECOVER.
  - RECOVER: cs_n high for 2 half-periods, then IDLE.
- Reset (rstb low at a clk edge), including mid-frame, forces on the next edge:
  - state IDLE, spi_cs_n=1, spi_clk=1, spi_mosi=0;
  - rsp_valid, rsp_rdata, rsp_status, rsp_err, busy all 0; req_ready=1;
  - any pending response is dropped.
- req_valid during busy is not accepted and need not be held stable.

## Timing
- Half-period tick: every CLK_DIV enabled cycles. The divider restarts on accept.
- Accept → spi_cs_n low: 1 cycle.
- Accept → rsp_valid: 36·CLK_DIV + 1 cycles (144 + 1 at the default).
- rsp_valid → req_ready: 2·CLK_DIV cycles. The minimum request spacing is therefore 38·CLK_DIV + 1.
- rsp_* outputs hold their values until the next rsp_valid.
- ena low stalls the divider; spi_clk never glitches.

## Configuration
- SPI_REG_MASTER_WRITE_VERIFY_EN defined:
  - After a write frame's RECOVER, an automatic read frame to the same address runs, with no IDLE in between.
  - rsp_valid fires only after the read frame.
  - rsp_rdata = readback; rsp_err = (readback != wdata).
  - Write latency = 74·CLK_DIV + 1.
- Undefined: rsp_err is constant 0, and writes respond after a single frame.

## Structure
- Package spi_reg_pkg holds:
  - the CPOL/CPHA constants;
  - RW_BIT = REG_W-1;
  - the master state enum (IDLE, SETUP, BYTE, GAP, HOLD, RECOVER).
- Sub-module spi_clk_div generates the half-period tick. Inputs: clk, rstb, ena, restart. Output: tick.

## Test plan
- Write: addr 5, wdata 0xA5, miso tied 1 → MOSI bytes 0x85 then 0xA5; rsp_status 0xFF; rsp_rdata 0x00; rsp_valid at accept + 145.
- Read: addr 2, slave model returns status 0x3C and data 0x5A → MOSI 0x02 then 0x00; rsp_status 0x3C; rsp_rdata 0x5A.
- Back-to-back: req_valid held for two requests → second accept exactly 8 cycles after the first rsp_valid; cs_n high ≥ 8 cycles between frames.
- ena toggled every other cycle during a read → same bit stream, all delays doubled, response unchanged.
- rstb low mid byte 0 → next edge: cs_n=1, clk=1, busy=0, no rsp_valid; a new request then completes normally.
- With SPI_REG_MASTER_WRITE_VERIFY_EN: write 0x11 to a slave that returns 0x10 → two frames, rsp_err=1, rsp_rdata=0x10 at accept + 297.
